// File: rtl/sum_disp_scan.sv
// Latches the adder sum/carry and shows it as 8 hex digits on a multiplexed
// common-anode 7-segment display. Optional macro: SUM_DISP_BLANK_EN (leading-zero blanking).
module sum_disp_scan #(
  parameter int unsigned SCAN_DIV = 50000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic [31:0] s,
  input  logic        co,
  output logic [7:0]  an,
  output logic [6:0]  seg,
  output logic        dp,
  output logic        valid
);

  localparam int unsigned PC_W   = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int unsigned IDX_W  = 3;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned SEG_W  = 7;
  localparam int unsigned DIG_N  = 8;

  localparam logic [PC_W-1:0] PC_LAST = PC_W'(SCAN_DIV - 1);

  logic [PC_W-1:0]   pc_q,      pc_d;
  logic [IDX_W-1:0]  idx_q,     idx_d;
  logic [DATA_W-1:0] pend_s_q,  pend_s_d;
  logic              pend_co_q, pend_co_d;
  logic              pend_q,    pend_d;
  logic [DATA_W-1:0] cur_s_q,   cur_s_d;
  logic              cur_co_q,  cur_co_d;
  logic              commit_q,  commit_d;
  logic [DIG_N-1:0]  an_q,      an_d;
  logic [SEG_W-1:0]  seg_q,     seg_d;
  logic              dp_q,      dp_d;
  logic              valid_q,   valid_d;

  logic              boundary_c;
  logic [3:0]        nibble_c;
  logic              blank_c;

  // Active-low g..a pattern for one hex digit.
  function automatic logic [SEG_W-1:0] hex7(input logic [3:0] n);
    logic [SEG_W-1:0] r;
    r = 7'h7F;
    case (n)
      4'h0: r = 7'h40;
      4'h1: r = 7'h79;
      4'h2: r = 7'h24;
      4'h3: r = 7'h30;
      4'h4: r = 7'h19;
      4'h5: r = 7'h12;
      4'h6: r = 7'h02;
      4'h7: r = 7'h78;
      4'h8: r = 7'h00;
      4'h9: r = 7'h10;
      4'hA: r = 7'h08;
      4'hB: r = 7'h03;
      4'hC: r = 7'h46;
      4'hD: r = 7'h21;
      4'hE: r = 7'h06;
      4'hF: r = 7'h0E;
      default: r = 7'h7F;
    endcase
    return r;
  endfunction

  assign boundary_c = (pc_q == PC_LAST);

  // Scan counters plus pending/committed value handling; commits only at slot boundaries.
  always_comb begin
    pc_d      = pc_q + PC_W'(1);
    idx_d     = idx_q;
    pend_s_d  = pend_s_q;
    pend_co_d = pend_co_q;
    pend_d    = pend_q;
    cur_s_d   = cur_s_q;
    cur_co_d  = cur_co_q;
    commit_d  = commit_q;

    if (boundary_c) begin
      pc_d  = '0;
      idx_d = idx_q + IDX_W'(1);
      if (load) begin
        cur_s_d  = s;
        cur_co_d = co;
        pend_d   = 1'b0;
        commit_d = 1'b1;
      end else if (pend_q) begin
        cur_s_d  = pend_s_q;
        cur_co_d = pend_co_q;
        pend_d   = 1'b0;
        commit_d = 1'b1;
      end
    end else if (load) begin
      pend_s_d  = s;
      pend_co_d = co;
      pend_d    = 1'b1;
    end
  end

  assign nibble_c = cur_s_q[{idx_q, 2'b00} +: 4];

`ifdef SUM_DISP_BLANK_EN
  // A digit blanks when it and every more-significant nibble are zero,
  // except digit 0 and a digit 7 that carries the carry-out point.
  always_comb begin
    blank_c = 1'b0;
    if ((idx_q != IDX_W'(0)) && ((cur_s_q >> {idx_q, 2'b00}) == DATA_W'(0))) begin
      blank_c = !((idx_q == IDX_W'(DIG_N - 1)) && cur_co_q);
    end
  end
`else
  assign blank_c = 1'b0;
`endif

  // Display drive, one cycle behind idx/cur.
  always_comb begin
    an_d    = '1;
    seg_d   = '1;
    dp_d    = 1'b1;
    valid_d = commit_q;
    if (commit_q) begin
      an_d  = ~(DIG_N'(1) << idx_q);
      seg_d = blank_c ? '1 : hex7(nibble_c);
      dp_d  = !((idx_q == IDX_W'(DIG_N - 1)) && cur_co_q);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q      <= '0;
      idx_q     <= '0;
      pend_s_q  <= '0;
      pend_co_q <= 1'b0;
      pend_q    <= 1'b0;
      cur_s_q   <= '0;
      cur_co_q  <= 1'b0;
      commit_q  <= 1'b0;
      an_q      <= '1;
      seg_q     <= '1;
      dp_q      <= 1'b1;
      valid_q   <= 1'b0;
    end else begin
      pc_q      <= pc_d;
      idx_q     <= idx_d;
      pend_s_q  <= pend_s_d;
      pend_co_q <= pend_co_d;
      pend_q    <= pend_d;
      cur_s_q   <= cur_s_d;
      cur_co_q  <= cur_co_d;
      commit_q  <= commit_d;
      an_q      <= an_d;
      seg_q     <= seg_d;
      dp_q      <= dp_d;
      valid_q   <= valid_d;
    end
  end

  assign an    = an_q;
  assign seg   = seg_q;
  assign dp    = dp_q;
  assign valid = valid_q;

endmodule

// File: tb/tb_sum_disp_scan.sv
// Directed self-checking bench for sum_disp_scan with SCAN_DIV = 4.
module tb_sum_disp_scan;

  localparam int SD = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        load;
  logic [31:0] s;
  logic        co;
  logic [7:0]  an;
  logic [6:0]  seg;
  logic        dp;
  logic        valid;

  int checks = 0;
  int failures = 0;
  int cyc;
  logic [6:0] exp_seg [8];
  int cnt [8];

  sum_disp_scan #(.SCAN_DIV(SD)) dut (
    .clk(clk), .rst(rst), .load(load), .s(s), .co(co),
    .an(an), .seg(seg), .dp(dp), .valid(valid)
  );

  always #5 clk = ~clk;

  // Edges since reset release; pc of the DUT equals cyc % SD between edges.
  always @(posedge clk or posedge rst) begin
    if (rst) cyc <= 0;
    else     cyc <= cyc + 1;
  end

  function automatic int lowhot(input logic [7:0] a);
    int r;
    r = -1;
    for (int i = 0; i < 8; i++) if (a === ~(8'b1 << i)) r = i;
    return r;
  endfunction

  task automatic wait_pc(input int p);
    int n;
    n = 0;
    while ((cyc % SD) != p && n < 16) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if ((cyc % SD) != p) begin
      failures++;
      $display("FAIL wait_pc: pc=%0d required=%0d", cyc % SD, p);
    end
  endtask

  task automatic test_reset;
    rst = 1'b1; load = 1'b0; s = '0; co = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if ({an, seg, dp, valid} !== {8'hFF, 7'h7F, 1'b1, 1'b0}) begin
      failures++;
      $display("FAIL reset_state: an=%h seg=%h dp=%b valid=%b required FF/7F/1/0", an, seg, dp, valid);
    end
    rst = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      checks++;
      if ({an, seg, dp, valid} !== {8'hFF, 7'h7F, 1'b1, 1'b0}) begin
        failures++;
        $display("FAIL idle_cycle%0d: an=%h seg=%h dp=%b valid=%b required FF/7F/1/0", k, an, seg, dp, valid);
      end
    end
  endtask

  task automatic test_load_mid;
    int d;
    wait_pc(1);
    s = 32'h00012B66; co = 1'b0; load = 1'b1;
    @(negedge clk);
    load = 1'b0;
    repeat (SD + 2) @(negedge clk);
    checks++;
    if (valid !== 1'b1) begin
      failures++;
      $display("FAIL mid_valid: valid=%b required 1", valid);
    end
    exp_seg = '{7'h02, 7'h02, 7'h03, 7'h24, 7'h79, 7'h40, 7'h40, 7'h40};
`ifdef SUM_DISP_BLANK_EN
    exp_seg[5] = 7'h7F; exp_seg[6] = 7'h7F; exp_seg[7] = 7'h7F;
`endif
    for (int i = 0; i < 8; i++) cnt[i] = 0;
    for (int k = 0; k < 8 * SD; k++) begin
      d = lowhot(an);
      checks++;
      if (d < 0) begin
        failures++;
        $display("FAIL mid_an: an=%h required a single low bit", an);
      end else begin
        cnt[d]++;
        checks++;
        if (seg !== exp_seg[d] || dp !== 1'b1) begin
          failures++;
          $display("FAIL mid_digit%0d: seg=%h dp=%b required %h/1", d, seg, dp, exp_seg[d]);
        end
      end
      @(negedge clk);
    end
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (cnt[i] != SD) begin
        failures++;
        $display("FAIL slot_len%0d: cycles=%0d required %0d", i, cnt[i], SD);
      end
    end
  endtask

  task automatic test_zero_carry;
    int d;
    s = 32'h0; co = 1'b1; load = 1'b1;
    @(negedge clk);
    load = 1'b0;
    repeat (SD + 2) @(negedge clk);
`ifdef SUM_DISP_BLANK_EN
    exp_seg = '{7'h40, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h40};
`else
    exp_seg = '{7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40};
`endif
    for (int k = 0; k < 8 * SD; k++) begin
      d = lowhot(an);
      checks++;
      if (d < 0) begin
        failures++;
        $display("FAIL zc_an: an=%h required a single low bit", an);
      end else begin
        checks++;
        if (seg !== exp_seg[d] || dp !== (d == 7 ? 1'b0 : 1'b1)) begin
          failures++;
          $display("FAIL zc_digit%0d: seg=%h dp=%b required %h/%b", d, seg, dp, exp_seg[d], (d == 7 ? 1'b0 : 1'b1));
        end
      end
      @(negedge clk);
    end
  endtask

  task automatic test_back_to_back;
    int d;
    wait_pc(0);
    s = 32'h11111111; co = 1'b0; load = 1'b1;
    @(negedge clk);
    load = 1'b0;
    @(negedge clk);
    s = 32'h22222222; load = 1'b1;
    @(negedge clk);
    load = 1'b0;
    for (int k = 0; k < SD + 2; k++) begin
      checks++;
      if (seg === 7'h79) begin
        failures++;
        $display("FAIL b2b_stale: seg=%h required not 79", seg);
      end
      @(negedge clk);
    end
    for (int k = 0; k < 8 * SD; k++) begin
      d = lowhot(an);
      checks++;
      if (d < 0 || seg !== 7'h24 || dp !== 1'b1) begin
        failures++;
        $display("FAIL b2b_digit: an=%h seg=%h dp=%b required one-low/24/1", an, seg, dp);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_boundary_load;
    int nidx;
    int n;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    n = 0;
    while (cyc != 7 && n < 20) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (cyc != 7) begin
      failures++;
      $display("FAIL bnd_align: cyc=%0d required 7", cyc);
    end
    nidx = ((cyc + 1) / SD) % 8;
    s = 32'hFFFFFFFF; co = 1'b0; load = 1'b1;
    @(negedge clk);
    load = 1'b0;
    checks++;
    if (valid !== 1'b0 || an !== 8'hFF) begin
      failures++;
      $display("FAIL bnd_early: valid=%b an=%h required 0/FF", valid, an);
    end
    @(negedge clk);
    checks++;
    if (valid !== 1'b1 || an !== ~(8'b1 << nidx) || seg !== 7'h0E || dp !== 1'b1) begin
      failures++;
      $display("FAIL bnd_show: valid=%b an=%h seg=%h dp=%b required 1/%h/0E/1", valid, an, seg, dp, ~(8'b1 << nidx));
    end
  endtask

  task automatic test_reset_pending;
    wait_pc(0);
    s = 32'h33333333; co = 1'b1; load = 1'b1;
    @(negedge clk);
    load = 1'b0;
    rst = 1'b1;
    #1;
    checks++;
    if ({an, seg, dp, valid} !== {8'hFF, 7'h7F, 1'b1, 1'b0}) begin
      failures++;
      $display("FAIL rst_async: an=%h seg=%h dp=%b valid=%b required FF/7F/1/0", an, seg, dp, valid);
    end
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      checks++;
      if ({an, seg, dp, valid} !== {8'hFF, 7'h7F, 1'b1, 1'b0}) begin
        failures++;
        $display("FAIL rst_pend_cycle%0d: an=%h seg=%h dp=%b valid=%b required FF/7F/1/0", k, an, seg, dp, valid);
      end
    end
  endtask

  initial begin
    test_reset();
    test_load_mid();
    test_zero_carry();
    test_back_to_back();
    test_boundary_load();
    test_reset_pending();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sum_disp_scan.md
# sum_disp_scan

Downstream display stage for the 32-bit carry-lookahead adder on the sum board. It captures the adder's sum `s` and carry-out `co` on a load strobe and shows the sum as 8 hex digits on a time-multiplexed, common-anode 7-segment display. The carry-out is shown on the decimal point of the most significant digit. A new value is applied only at a digit-slot boundary, so the display never changes in the middle of a digit.

## Interface
- `SCAN_DIV`, default 50000: clock cycles per digit slot; must be ≥ 2.
- `clk`  in  1  system clock; all logic on the rising edge.
- `rst`  in  1  reset; asynchronous and active-high.
- `load`  in  1  one-cycle strobe; capture `s`/`co` this cycle.
- `s`  in  32  sum from the adder.
- `co`  in  1  carry-out from the adder.
- `an`  out  8  digit enables, active-low; `an[i]` drives hex digit i (nibble `s[4i+3:4i]`).
- `seg`  out  7  segments, active-low; `seg[0]`=a … `seg[6]`=g.
- `dp`  out  1  decimal point, active-low.
- `valid`  out  1  high once any value has been committed.

## Operation
- Registers:
  - prescaler `pc` counts 0..SCAN_DIV-1 and wraps.
  - digit index `idx` (3 bits) counts 0..7 and wraps.
  - pending buffer holds `pend_s`, `pend_co` and the flag `pend`.
  - committed value holds `cur_s` and `cur_co`.
- Boundary cycle: `pc == SCAN_DIV-1`. On this edge `pc` becomes 0 and `idx` becomes idx+1 mod 8.
- Load, non-boundary cycle: `pend_s`/`pend_co` take `s`/`co` and `pend` is set. A later load overwrites the buffer; the newest load wins.
- Boundary cycle without load: if `pend` is set, `cur` takes the pending value, `pend` clears and `valid` sets.
- Load on a boundary cycle: the incoming `s`/`co` go directly into `cur`, and `valid` sets. Any older pending value is discarded and `pend` clears.
- While `valid` = 0: `an` = 8'hFF, `seg` = 7'h7F, `dp` = 1. Counters keep running.
- While `valid` = 1:
  - `an` = ~(1 << idx).
  - `seg` = hex decode of nibble idx of `cur_s`.
  - `dp` = 0 only when idx = 7 and `cur_co` = 1.
- Hex decode (`seg`, active-low, g..a):
  - 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78
  - 8=00, 9=10, A=08, b=03, C=46, d=21, E=06, F=0E
- Reset state, entered asynchronously at any time including mid-slot or with a pending load:
  - `pc`, `idx`, `cur_*`, `pend_*` all 0.
  - `an` = 8'hFF, `seg` = 7'h7F, `dp` = 1, `valid` = 0.

## Timing
- `an`, `seg`, `dp` and `valid` are registered outputs, with 1-cycle latency from `idx`/`cur`.
- The first digit-0 slot after reset release begins with `pc` = 0. The first boundary occurs SCAN_DIV cycles after reset release.
- Load → visible: the value appears on the outputs 1 cycle after the first boundary at or after the load.
  - Worst case is SCAN_DIV+1 cycles.
  - A load on a boundary cycle is visible 1 cycle later.
- Each digit is enabled for exactly SCAN_DIV cycles. The full refresh frame is 8·SCAN_DIV cycles.
- `load` held high for several cycles behaves as repeated loads; the last captured value wins.

## Configuration
- `SUM_DISP_BLANK_EN` defined: leading-zero blanking.
  - A digit i > 0 shows `seg` = 7'h7F when all nibbles i..7 of `cur_s` are zero.
  - Digit 0 is never blanked.
  - Digit 7 is not blanked when `cur_co` = 1; it shows 0 with `dp` = 0.
  - `an` scanning is unchanged.
- `SUM_DISP_BLANK_EN` not defined: all 8 digits always decode, including leading zeros.

## Test plan
Run all scenarios with SCAN_DIV = 4.
- Reset, then 40 cycles with no load → `an` = FF, `seg` = 7F, `dp` = 1, `valid` = 0 throughout.
- Load `s` = 32'd76646 (0x00012B66), `co` = 0, mid-slot → one full frame shows digits 0..7 as 02, 02, 03, 24, 79, 40, 40, 40; `dp` = 1.
  - With the macro, digits 5..7 show 7F.
- Load `s` = 0, `co` = 1 → digit 7 shows `seg` = 40 with `dp` = 0; digits 0..6 show 40.
  - With the macro, digits 1..6 show 7F and digits 0 and 7 show 40.
- Load 0x11111111, then load 0x22222222 two cycles later, both before the same boundary → only 0x22222222 is ever displayed (every digit 24).
- Load 0xFFFFFFFF exactly on a boundary cycle → the next cycle shows `seg` = 0E on the new idx; `valid` rises the same cycle.
- Assert `rst` mid-slot with a load pending → outputs return to FF/7F/1 and `valid` = 0 immediately. After release, the pending value is never displayed.
